// File: rtl/smc_pkg.sv
// smc_pkg: shared widths, device record and driver state encoding
// for the SMC sequential front end.
package smc_pkg;

   localparam int DW      = 3;
   localparam int OW      = 8;
   localparam int NUM_DEV = 6;

   typedef struct packed {
      logic [DW-1:0] w;
      logic [DW-1:0] vgs;
      logic [DW-1:0] vds;
   } dev_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_OUT
   } state_t;

endpackage

// File: rtl/smc_driver.sv
// smc_driver: collects six MOSFET records over a 6-beat valid/ready
// stream, holds them stable for SMC, waits SETTLE cycles, then
// captures out_n and strobes out_valid for one cycle.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   host beat handshake
//   in_mode,in_w,       beat payload (mode used on beat 0 only)
//   in_vgs,in_vds
//   mode,W_*,V_GS_*,    registered, stable inputs to SMC
//   V_DS_*
//   out_n               SMC result
//   out_valid           one-cycle result strobe
//   out_result          captured out_n, held until next capture
//   tx_count            completed transactions, modulo 256
module smc_driver #(
   parameter int SETTLE = 1,
   parameter int DW     = smc_pkg::DW,
   parameter int OW     = smc_pkg::OW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_mode,
   input  logic [DW-1:0] in_w,
   input  logic [DW-1:0] in_vgs,
   input  logic [DW-1:0] in_vds,
   output logic [1:0]    mode,
   output logic [DW-1:0] W_0,
   output logic [DW-1:0] W_1,
   output logic [DW-1:0] W_2,
   output logic [DW-1:0] W_3,
   output logic [DW-1:0] W_4,
   output logic [DW-1:0] W_5,
   output logic [DW-1:0] V_GS_0,
   output logic [DW-1:0] V_GS_1,
   output logic [DW-1:0] V_GS_2,
   output logic [DW-1:0] V_GS_3,
   output logic [DW-1:0] V_GS_4,
   output logic [DW-1:0] V_GS_5,
   output logic [DW-1:0] V_DS_0,
   output logic [DW-1:0] V_DS_1,
   output logic [DW-1:0] V_DS_2,
   output logic [DW-1:0] V_DS_3,
   output logic [DW-1:0] V_DS_4,
   output logic [DW-1:0] V_DS_5,
   input  logic [OW-1:0] out_n,
   output logic          out_valid,
   output logic [OW-1:0] out_result,
   output logic [7:0]    tx_count
);

   import smc_pkg::*;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
   localparam logic [2:0] LAST     = 3'(NUM_DEV - 1);

   state_t        r_state;
   logic [2:0]    r_idx;
   logic [3:0]    r_cnt;
   logic [1:0]    r_mode;
   logic [DW-1:0] r_w   [NUM_DEV];
   logic [DW-1:0] r_vgs [NUM_DEV];
   logic [DW-1:0] r_vds [NUM_DEV];
   logic          r_ovalid;
   logic [OW-1:0] r_result;
   logic [7:0]    r_tx;

   logic          w_ready;
   logic          w_acc;
   logic [2:0]    w_slot;

   assign w_ready = (r_state != ST_SETTLE);
   assign w_acc   = in_valid && w_ready;
   // IDLE and OUT always start a new record set at slot 0
   assign w_slot  = (r_state == ST_LOAD) ? r_idx : 3'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_mode   <= '0;
         r_ovalid <= 1'b0;
         r_result <= '0;
         r_tx     <= '0;
         for (int i = 0; i < NUM_DEV; i++) begin
            r_w[i]   <= '0;
            r_vgs[i] <= '0;
            r_vds[i] <= '0;
         end
      end else begin
         if (w_acc) begin
            r_w[w_slot]   <= in_w;
            r_vgs[w_slot] <= in_vgs;
            r_vds[w_slot] <= in_vds;
            if (w_slot == 3'd0) r_mode <= in_mode;
         end
         unique case (r_state)
            ST_IDLE: begin
               if (w_acc) begin
                  r_idx   <= 3'd1;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_acc) begin
                  if (r_idx == LAST) begin
                     r_idx   <= '0;
                     r_cnt   <= CNT_INIT;
                     r_state <= ST_SETTLE;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end
            end
            ST_SETTLE: begin
               if (r_cnt == 4'd0) begin
                  r_result <= out_n;
                  r_ovalid <= 1'b1;
                  r_tx     <= r_tx + 8'd1;
                  r_state  <= ST_OUT;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_OUT: begin
               r_ovalid <= 1'b0;
               if (w_acc) begin
                  r_idx   <= 3'd1;
                  r_state <= ST_LOAD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = w_ready;
   assign mode       = r_mode;
   assign out_valid  = r_ovalid;
   assign out_result = r_result;
   assign tx_count   = r_tx;

   assign W_0    = r_w[0];
   assign W_1    = r_w[1];
   assign W_2    = r_w[2];
   assign W_3    = r_w[3];
   assign W_4    = r_w[4];
   assign W_5    = r_w[5];
   assign V_GS_0 = r_vgs[0];
   assign V_GS_1 = r_vgs[1];
   assign V_GS_2 = r_vgs[2];
   assign V_GS_3 = r_vgs[3];
   assign V_GS_4 = r_vgs[4];
   assign V_GS_5 = r_vgs[5];
   assign V_DS_0 = r_vds[0];
   assign V_DS_1 = r_vds[1];
   assign V_DS_2 = r_vds[2];
   assign V_DS_3 = r_vds[3];
   assign V_DS_4 = r_vds[4];
   assign V_DS_5 = r_vds[5];

endmodule

// File: tb/tb_smc_driver.sv
// tb_smc_driver: two driver instances (SETTLE=1 and SETTLE=4), each
// feeding a stub SMC that sums all 18 fields.
module tb_smc_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic             iv  [2];
   logic [1:0]       im  [2];
   logic [2:0]       iw  [2];
   logic [2:0]       ig  [2];
   logic [2:0]       id  [2];
   logic             ird [2];
   logic [1:0]       mo  [2];
   logic [5:0][2:0]  wo  [2];
   logic [5:0][2:0]  go  [2];
   logic [5:0][2:0]  do_ [2];
   logic [7:0]       on  [2];
   logic             ov  [2];
   logic [7:0]       res [2];
   logic [7:0]       tx  [2];

   int SV [2] = '{1, 4};

   function automatic logic [7:0] stub_sum(
      input logic [5:0][2:0] a, b, c);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < 6; i++)
         s += 8'(a[i]) + 8'(b[i]) + 8'(c[i]);
      return s;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign on[g] = stub_sum(wo[g], go[g], do_[g]);
      smc_driver #(
         .SETTLE(g == 0 ? 1 : 4)
      ) u_dut (
         .clk(clk), .rst(rst),
         .in_valid(iv[g]), .in_ready(ird[g]),
         .in_mode(im[g]), .in_w(iw[g]),
         .in_vgs(ig[g]), .in_vds(id[g]),
         .mode(mo[g]),
         .W_0(wo[g][0]), .W_1(wo[g][1]), .W_2(wo[g][2]),
         .W_3(wo[g][3]), .W_4(wo[g][4]), .W_5(wo[g][5]),
         .V_GS_0(go[g][0]), .V_GS_1(go[g][1]),
         .V_GS_2(go[g][2]), .V_GS_3(go[g][3]),
         .V_GS_4(go[g][4]), .V_GS_5(go[g][5]),
         .V_DS_0(do_[g][0]), .V_DS_1(do_[g][1]),
         .V_DS_2(do_[g][2]), .V_DS_3(do_[g][3]),
         .V_DS_4(do_[g][4]), .V_DS_5(do_[g][5]),
         .out_n(on[g]), .out_valid(ov[g]),
         .out_result(res[g]), .tx_count(tx[g])
      );
   end

   typedef struct {
      int         g;
      logic [7:0] res;
      int         due;
      logic [7:0] tx;
   } ent_t;

   ent_t       q [$];
   logic [7:0] txm [2];
   logic       pov [2];
   ent_t       me;

   task automatic chk(input string tag,
                      input logic [63:0] got, exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic fail(input string tag);
      checks++;
      errors++;
      $error("FAIL %s", tag);
   endtask

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (ov[g] === 1'b1) begin
            chk("ov_one_cycle", pov[g], 0);
            if (q.size() == 0) begin
               fail("spurious_out_valid");
            end else begin
               me = q.pop_front();
               chk("ov_inst", g, me.g);
               chk("out_result", res[g], me.res);
               chk("latency", cyc, me.due);
               chk("tx_count", tx[g], me.tx);
            end
         end
         pov[g] = ov[g];
      end
   end

   task automatic beat(input int g, input logic [1:0] m,
                       input logic [2:0] w, v, d,
                       output int kc);
      int n;
      @(negedge clk);
      iv[g] = 1'b1; im[g] = m;
      iw[g] = w; ig[g] = v; id[g] = d;
      n = 0;
      while (ird[g] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) fail("ready_timeout");
      @(posedge clk);
      #1;
      kc = cyc;
   endtask

   task automatic idle(input int g, input int n);
      repeat (n) begin
         @(negedge clk);
         iv[g] = 1'b0;
      end
   endtask

   task automatic xact(input int g, input logic [1:0] m,
                       input logic [5:0][2:0] w, v, d,
                       input int st_at, input int st_n,
                       input bit junk,
                       output int k0, output int k5);
      int   k;
      ent_t e;
      k = 0;
      k0 = 0;
      for (int i = 0; i < 6; i++) begin
         // only beat 0 may change mode
         beat(g, (i == 0) ? m : ~m, w[i], v[i], d[i], k);
         if (i == 0) k0 = k;
         if (i == st_at) begin
            for (int s = 0; s < st_n; s++) begin
               @(negedge clk);
               iv[g] = 1'b0;
               chk("stall_ready", ird[g], 1);
            end
         end
      end
      k5 = k;
      txm[g] = txm[g] + 8'd1;
      e.g = g;
      e.res = stub_sum(w, v, d);
      e.due = k5 + SV[g];
      e.tx = txm[g];
      q.push_back(e);
      for (int s = 0; s < SV[g]; s++) begin
         @(negedge clk);
         iv[g] = junk;
         iw[g] = 3'($urandom);
         ig[g] = 3'($urandom);
         id[g] = 3'($urandom);
         im[g] = 2'($urandom);
         chk("settle_ready", ird[g], 0);
         chk("frozen", {wo[g], go[g], do_[g]}, {w, v, d});
         chk("frozen_mode", mo[g], m);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) fail("out_valid_timeout");
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      iv[0] = 1'b0;
      iv[1] = 1'b0;
      q.delete();
      txm[0] = '0;
      txm[1] = '0;
      #1;
      chk("rst_ov", ov[0], 0);
      chk("rst_res", res[0], 0);
      chk("rst_tx", tx[0], 0);
      chk("rst_mode", mo[0], 0);
      chk("rst_fields", {wo[0], go[0], do_[0]}, 0);
      chk("rst_ready", ird[0], 1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0][2:0] a, b, c;
      int k0, k5, ka5, kb0, kd;
      for (int g = 0; g < 2; g++) begin
         iv[g] = 1'b0; im[g] = '0;
         iw[g] = '0; ig[g] = '0; id[g] = '0;
         pov[g] = 1'b0;
      end
      repeat (2) @(negedge clk);
      do_reset();

      // all fields 7, mode 2
      for (int i = 0; i < 6; i++) a[i] = 3'd7;
      xact(0, 2'd2, a, a, a, -1, 0, 1'b0, k0, k5);
      idle(0, 3);
      drain();
      chk("t1_mode", mo[0], 2);
      chk("t1_res", res[0], 126);
      chk("t1_tx", tx[0], 1);

      // device i fields = i, 3-cycle stall after beat 2
      for (int i = 0; i < 6; i++) a[i] = 3'(i);
      xact(0, 2'd1, a, a, a, 2, 3, 1'b0, k0, k5);
      idle(0, 1);
      drain();
      chk("t2_res", res[0], 45);
      chk("t2_mode", mo[0], 1);

      // SETTLE=4 with junk beats during the settle window
      for (int i = 0; i < 6; i++) begin
         a[i] = 3'($urandom);
         b[i] = 3'($urandom);
         c[i] = 3'($urandom);
      end
      xact(1, 2'd3, a, b, c, -1, 0, 1'b1, k0, k5);
      idle(1, 1);
      drain();
      chk("t3_res", res[1], stub_sum(a, b, c));
      chk("t3_fields", {wo[1], go[1], do_[1]}, {a, b, c});
      chk("t3_mode", mo[1], 3);
      chk("t3_tx", tx[1], 1);

      // back-to-back: beat 0 of B in A's OUT cycle
      for (int i = 0; i < 6; i++) begin
         a[i] = 3'd3;
         b[i] = 3'd2;
      end
      xact(0, 2'd1, a, a, a, -1, 0, 1'b0, k0, ka5);
      xact(0, 2'd3, b, b, b, -1, 0, 1'b0, kb0, k5);
      chk("b2b_beat0", kb0, ka5 + 2);
      chk("b2b_hold", res[0], 54);
      idle(0, 1);
      drain();
      chk("b2b_res", res[0], 36);
      chk("b2b_tx", tx[0], 4);

      // reset after beat 3 discards the partial transaction
      for (int i = 0; i < 4; i++)
         beat(0, 2'd2, 3'd5, 3'd6, 3'd7, kd);
      do_reset();
      idle(0, 3);
      for (int i = 0; i < 6; i++) a[i] = 3'd1;
      xact(0, 2'd0, a, a, a, -1, 0, 1'b0, k0, k5);
      idle(0, 1);
      drain();
      chk("rst_after_res", res[0], 18);
      chk("rst_after_tx", tx[0], 1);

      // 256 back-to-back transactions: tx_count wraps to 0
      do_reset();
      for (int n = 0; n < 256; n++) begin
         for (int i = 0; i < 6; i++) begin
            a[i] = 3'($urandom);
            b[i] = 3'($urandom);
            c[i] = 3'($urandom);
         end
         xact(0, 2'($urandom), a, b, c, -1, 0, 1'b0, k0, k5);
      end
      idle(0, 1);
      drain();
      chk("wrap_tx", tx[0], 0);
      chk("wrap_res", res[0], stub_sum(a, b, c));
      chk("wrap_ready", ird[0], 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
